// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares one peripheral register block between the core bus
// master (c_*) and the debug port (d_*). One register access per transaction,
// bus parked as a read of address 0 when idle, illegal accesses flagged.
module regfile_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter logic [3:0]  MAX_ADDR   = 4'hC,
    parameter logic [15:0] RO_MASK    = 16'h0603
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [3:0]  c_addr,
    input  logic [3:0]  c_wben,
    input  logic [31:0] c_wdata,
    output logic        c_done,
    output logic        c_err,
    output logic [31:0] c_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_addr,
    input  logic [3:0]  d_wben,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic        d_err,
    output logic [31:0] d_rdata,

    output logic [3:0]  reg_addr,
    output logic [3:0]  reg_wben,
    output logic        reg_r_wn,
    output logic [31:0] reg_wdata,
    input  logic [31:0] reg_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;  // 1 = debug port got the last grant
    logic        gnt_d_q, gnt_d_d;            // current transaction belongs to debug
    logic        cmd_we_q, cmd_we_d;
    logic        cmd_err_q, cmd_err_d;

    logic        c_done_q, c_done_d;
    logic        c_err_q, c_err_d;
    logic [31:0] c_rdata_q, c_rdata_d;
    logic        d_done_q, d_done_d;
    logic        d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic [3:0]  reg_addr_q, reg_addr_d;
    logic [3:0]  reg_wben_q, reg_wben_d;
    logic        reg_r_wn_q, reg_r_wn_d;
    logic [31:0] reg_wdata_q, reg_wdata_d;

    logic        sel_d;
    logic        sel_we;
    logic [3:0]  sel_addr;
    logic [3:0]  sel_wben;
    logic [31:0] sel_wdata;
    logic        sel_err;

    // Grant selection and legality check of the command that would be latched
    always_comb begin
        // On a tie: fixed priority favours c, otherwise serve the one not granted last
        sel_d     = d_req & (~c_req | (~FIXED_PRIO & ~last_grant_q));
        sel_we    = sel_d ? d_we    : c_we;
        sel_addr  = sel_d ? d_addr  : c_addr;
        sel_wben  = sel_d ? d_wben  : c_wben;
        sel_wdata = sel_d ? d_wdata : c_wdata;
        // Address 3 is the pin-state register: readable, never writable
        sel_err   = (sel_addr > MAX_ADDR) |
                    (sel_we & (RO_MASK[sel_addr] | (sel_addr == 4'd3)));
    end

    // Next-state and registered-output computation for the IDLE/ACCESS/RESP sequence
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d_d      = gnt_d_q;
        cmd_we_d     = cmd_we_q;
        cmd_err_d    = cmd_err_q;
        c_done_d     = 1'b0;
        c_err_d      = 1'b0;
        c_rdata_d    = c_rdata_q;
        d_done_d     = 1'b0;
        d_err_d      = 1'b0;
        d_rdata_d    = d_rdata_q;
        reg_addr_d   = reg_addr_q;
        reg_wben_d   = 4'b0000;
        reg_r_wn_d   = 1'b1;
        reg_wdata_d  = 32'h0;

        unique case (state_q)
            StIdle: begin
                reg_addr_d = 4'h0;
                if (c_req || d_req) begin
                    state_d      = StAccess;
                    last_grant_d = sel_d;
                    gnt_d_d      = sel_d;
                    cmd_we_d     = sel_we;
                    cmd_err_d    = sel_err;
                    // Bus registers double as the latched address/wben/wdata
                    reg_addr_d   = sel_addr;
                    if (sel_we && !sel_err) begin
                        reg_r_wn_d  = 1'b0;
                        reg_wben_d  = sel_wben;
                        reg_wdata_d = sel_wdata;
                    end
                end
            end
            StAccess: begin
                state_d = StResp;
            end
            StResp: begin
                state_d    = StIdle;
                reg_addr_d = 4'h0;
                if (gnt_d_q) begin
                    d_done_d  = 1'b1;
                    d_err_d   = cmd_err_q;
                    d_rdata_d = (!cmd_we_q && !cmd_err_q) ? reg_rdata : 32'h0;
                end else begin
                    c_done_d  = 1'b1;
                    c_err_d   = cmd_err_q;
                    c_rdata_d = (!cmd_we_q && !cmd_err_q) ? reg_rdata : 32'h0;
                end
            end
            default: begin
                state_d    = StIdle;
                reg_addr_d = 4'h0;
            end
        endcase
    end

    // State and output registers; reset parks the bus as a read at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            gnt_d_q      <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_err_q    <= 1'b0;
            c_done_q     <= 1'b0;
            c_err_q      <= 1'b0;
            c_rdata_q    <= 32'h0;
            d_done_q     <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= 32'h0;
            reg_addr_q   <= 4'h0;
            reg_wben_q   <= 4'b0000;
            reg_r_wn_q   <= 1'b1;
            reg_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_d_q      <= gnt_d_d;
            cmd_we_q     <= cmd_we_d;
            cmd_err_q    <= cmd_err_d;
            c_done_q     <= c_done_d;
            c_err_q      <= c_err_d;
            c_rdata_q    <= c_rdata_d;
            d_done_q     <= d_done_d;
            d_err_q      <= d_err_d;
            d_rdata_q    <= d_rdata_d;
            reg_addr_q   <= reg_addr_d;
            reg_wben_q   <= reg_wben_d;
            reg_r_wn_q   <= reg_r_wn_d;
            reg_wdata_q  <= reg_wdata_d;
        end
    end

    assign c_done    = c_done_q;
    assign c_err     = c_err_q;
    assign c_rdata   = c_rdata_q;
    assign d_done    = d_done_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wben  = reg_wben_q;
    assign reg_r_wn  = reg_r_wn_q;
    assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: a round-robin instance wired to a small register
// block model, plus a fixed-priority instance sharing the same requester inputs.
module tb_regfile_arbiter;

    localparam logic [31:0] ID_VAL  = 32'h4852_4a44;
    localparam logic [31:0] VER_VAL = 32'h0001_0002;
    localparam logic [31:0] PIN_VAL = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, rb_rst_n;
    logic        c_req, c_we, d_req, d_we;
    logic [3:0]  c_addr, c_wben, d_addr, d_wben;
    logic [31:0] c_wdata, d_wdata;

    logic        c_done, c_err, d_done, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic [3:0]  reg_addr, reg_wben;
    logic        reg_r_wn;
    logic [31:0] reg_wdata, reg_rdata;

    logic        p1_c_done, p1_c_err, p1_d_done, p1_d_err, p1_reg_r_wn;
    logic [31:0] p1_c_rdata, p1_d_rdata, p1_reg_wdata;
    logic [3:0]  p1_reg_addr, p1_reg_wben;
    logic [31:0] zero32;
    assign zero32 = 32'h0;

    regfile_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wben(c_wben), .c_wdata(c_wdata),
        .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wben(d_wben), .d_wdata(d_wdata),
        .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .reg_addr(reg_addr), .reg_wben(reg_wben), .reg_r_wn(reg_r_wn),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
    );

    regfile_arbiter #(.FIXED_PRIO(1'b1)) dut_prio (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wben(c_wben), .c_wdata(c_wdata),
        .c_done(p1_c_done), .c_err(p1_c_err), .c_rdata(p1_c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wben(d_wben), .d_wdata(d_wdata),
        .d_done(p1_d_done), .d_err(p1_d_err), .d_rdata(p1_d_rdata),
        .reg_addr(p1_reg_addr), .reg_wben(p1_reg_wben), .reg_r_wn(p1_reg_r_wn),
        .reg_wdata(p1_reg_wdata), .reg_rdata(zero32)
    );

    // Register block model: byte-enabled writes, one-cycle registered read data.
    // Own reset so its contents survive arbiter resets.
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (!rb_rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0]    <= ID_VAL;
            mem[1]    <= VER_VAL;
            mem[3]    <= PIN_VAL;
            reg_rdata <= 32'h0;
        end else begin
            if (!reg_r_wn) begin
                for (int b = 0; b < 4; b++)
                    if (reg_wben[b]) mem[reg_addr][8*b +: 8] <= reg_wdata[8*b +: 8];
            end
            reg_rdata <= mem[reg_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        c_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One transaction on one port; req held until done (bounded wait)
    task automatic run_txn(input logic is_d, input logic we, input logic [3:0] addr,
                           input logic [3:0] wben, input logic [31:0] wdata,
                           output int lat, output logic err, output logic [31:0] rdata,
                           output int wr_cyc, output logic [3:0] wr_wben,
                           output logic [3:0] wr_addr, output int other_done);
        lat = 0; err = 1'b0; rdata = 32'hx; wr_cyc = 0;
        wr_wben = 4'h0; wr_addr = 4'h0; other_done = 0;
        @(negedge clk);
        if (is_d) begin
            d_we = we; d_addr = addr; d_wben = wben; d_wdata = wdata; d_req = 1'b1;
        end else begin
            c_we = we; c_addr = addr; c_wben = wben; c_wdata = wdata; c_req = 1'b1;
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!reg_r_wn) begin
                wr_cyc++;
                wr_wben = reg_wben;
                wr_addr = reg_addr;
            end
            if (is_d ? c_done : d_done) other_done++;
            if (is_d ? d_done : c_done) begin
                lat   = k;
                err   = is_d ? d_err : c_err;
                rdata = is_d ? d_rdata : c_rdata;
                break;
            end
        end
        c_req = 1'b0;
        d_req = 1'b0;
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [3:0]  addr;
        logic [3:0]  wben;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_wr;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int          lat, wr_cyc, other;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  wr_wben, wr_addr;
        int          n, overlap, p1_c, p1_d, nc, kd, dones;
        int          order[4];
        int          tdone[4];

        //          is_d  we    addr   wben     wdata          err   rdata         wr
        vecs[0]  = '{1'b0, 1'b0, 4'h0, 4'b0000, 32'h0,         1'b0, ID_VAL,       0};
        vecs[1]  = '{1'b1, 1'b1, 4'h6, 4'b0011, 32'hA5A5_1234, 1'b0, 32'h0,        1};
        vecs[2]  = '{1'b1, 1'b0, 4'h6, 4'b0000, 32'h0,         1'b0, 32'h0000_1234, 0};
        vecs[3]  = '{1'b0, 1'b1, 4'h1, 4'b1111, 32'hFFFF_FFFF, 1'b1, 32'h0,        0};
        vecs[4]  = '{1'b0, 1'b1, 4'h3, 4'b1111, 32'h1111_1111, 1'b1, 32'h0,        0};
        vecs[5]  = '{1'b1, 1'b0, 4'hE, 4'b0000, 32'h0,         1'b1, 32'h0,        0};
        vecs[6]  = '{1'b0, 1'b0, 4'h1, 4'b0000, 32'h0,         1'b0, VER_VAL,      0};
        vecs[7]  = '{1'b0, 1'b1, 4'h6, 4'b0000, 32'hFFFF_FFFF, 1'b0, 32'h0,        1};
        vecs[8]  = '{1'b1, 1'b0, 4'h6, 4'b0000, 32'h0,         1'b0, 32'h0000_1234, 0};
        vecs[9]  = '{1'b0, 1'b1, 4'hC, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0,        1};
        vecs[10] = '{1'b1, 1'b0, 4'hC, 4'b0000, 32'h0,         1'b0, 32'hCAFE_F00D, 0};
        vecs[11] = '{1'b0, 1'b1, 4'hD, 4'b1111, 32'h2222_2222, 1'b1, 32'h0,        0};
        vecs[12] = '{1'b1, 1'b1, 4'h9, 4'b0001, 32'h3333_3333, 1'b1, 32'h0,        0};
        vecs[13] = '{1'b0, 1'b0, 4'h3, 4'b0000, 32'h0,         1'b0, PIN_VAL,      0};

        reset = 1'b0; rb_rst_n = 1'b0;
        c_req = 1'b0; c_we = 1'b0; c_addr = 4'h0; c_wben = 4'h0; c_wdata = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 4'h0; d_wben = 4'h0; d_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done",  {30'h0, c_done, d_done}, 32'h0);
        check("rst_err",   {30'h0, c_err, d_err}, 32'h0);
        check("rst_c_rdata", c_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_bus",   {23'h0, reg_addr, reg_wben, reg_r_wn}, 32'h1);
        check("rst_wdata", reg_wdata, 32'h0);
        reset = 1'b1; rb_rst_n = 1'b1;

        // Single transactions from the vector table
        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wben, vecs[i].wdata,
                    lat, err, rdata, wr_cyc, wr_wben, wr_addr, other);
            check($sformatf("v%0d_latency", i), lat, 3);
            check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_wr_cycles", i), wr_cyc, vecs[i].exp_wr);
            check($sformatf("v%0d_other_done", i), other, 0);
            if (vecs[i].exp_wr != 0) begin
                check($sformatf("v%0d_wr_wben", i), {28'h0, wr_wben}, {28'h0, vecs[i].wben});
                check($sformatf("v%0d_wr_addr", i), {28'h0, wr_addr}, {28'h0, vecs[i].addr});
            end
        end

        // Tie with round-robin: c, d, c, d, 3 cycles apart; fixed-prio copy serves only c
        apply_reset();
        @(negedge clk);
        c_we = 1'b0; c_addr = 4'h0; d_we = 1'b0; d_addr = 4'h2;
        c_req = 1'b1; d_req = 1'b1;
        n = 0; overlap = 0; p1_c = 0; p1_d = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (c_done && d_done) overlap++;
            if (p1_c_done) p1_c++;
            if (p1_d_done) p1_d++;
            if (n < 4 && (c_done || d_done)) begin
                order[n] = d_done ? 1 : 0;
                tdone[n] = k;
                n++;
            end
            if (n == 4) break;
        end
        c_req = 1'b0; d_req = 1'b0;
        check("rr_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_order%0d", i), order[i], i % 2);
            check($sformatf("rr_time%0d", i), tdone[i], 3 * (i + 1));
        end
        check("rr_overlap", overlap, 0);
        check("prio_tie_c", p1_c, 4);
        check("prio_tie_d", p1_d, 0);

        // Fixed priority: d starved until c drops, then served on the next idle slot
        apply_reset();
        @(negedge clk);
        c_req = 1'b1; d_req = 1'b1;
        nc = 0; kd = 0; overlap = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (p1_c_done && p1_d_done) overlap++;
            if (p1_c_done) begin
                nc++;
                if (nc == 3) c_req = 1'b0;
            end
            if (p1_d_done) begin
                kd = k;
                break;
            end
        end
        c_req = 1'b0; d_req = 1'b0;
        check("prio_c_before_d", nc, 3);
        check("prio_d_time", kd, 12);
        check("prio_overlap", overlap, 0);

        // Reset during the ACCESS cycle of a write: bus drops to read at once, no done
        apply_reset();
        @(negedge clk);
        d_we = 1'b1; d_addr = 4'h6; d_wben = 4'b1111; d_wdata = 32'hFFFF_FFFF; d_req = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_access_rwn", {31'h0, reg_r_wn}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        d_req = 1'b0;
        #1;
        check("midrst_rwn", {31'h0, reg_r_wn}, 32'h1);
        check("midrst_wben", {28'h0, reg_wben}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (c_done || d_done) dones++;
        end
        check("midrst_no_done", dones, 0);
        run_txn(1'b1, 1'b0, 4'h6, 4'b0000, 32'h0, lat, err, rdata, wr_cyc, wr_wben, wr_addr,
                other);
        check("midrst_readback", rdata, 32'h0000_1234);
        check("midrst_read_err", {31'h0, err}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
